uart_tx: RTL and testbench

Serial UART transmitter directly downstream of the word-to-byte controller. Accepts one byte per Tx_Start/Tx_Busy handshake and shifts it out on a single line as a framed 8-bit character: start bit, data bits LSB first, optional parity, 1 or 2 stop bits. Bit timing comes from an internal baud counter driven by the system clock. No input buffering: the controller must wait for Tx_Busy low before issuing the next byte.

---
 rtl/uart_tx_if.sv | 19 +
 rtl/uart_tx.sv | 147 ++++++++++++++
 tb/tb_uart_tx.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake and serial line between the word-to-byte
// controller (master) and the UART transmitter (slave).
//   Tx_Start  master->slave  request to send Tx_Data
//   Tx_Data   master->slave  byte to transmit
//   Tx_Busy   slave->master  frame in progress
//   Tx        slave->master  serial line, idles high
//   Tx_Done   slave->master  one-cycle pulse at the end of the final stop bit
interface uart_tx_if;
  logic       Tx_Start;
  logic [7:0] Tx_Data;
  logic       Tx_Busy;
  logic       Tx;
  logic       Tx_Done;

  modport master (output Tx_Start, output Tx_Data,
                  input  Tx_Busy, input Tx, input Tx_Done);
  modport slave  (input  Tx_Start, input Tx_Data,
                  output Tx_Busy, output Tx, output Tx_Done);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter. Accepts one byte per Tx_Start/Tx_Busy
// handshake and sends start bit, 8 data bits LSB first, optional parity and
// 1 or 2 stop bits, each bit lasting CLKS_PER_BIT clocks.
//   Clock  system clock, rising edge
//   Reset  synchronous, active-high
//   bus    uart_tx_if.slave (Tx_Start, Tx_Data in; Tx_Busy, Tx, Tx_Done out)
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic     Clock,
  input  logic     Reset,
  uart_tx_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = 3;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(7);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic             PAR_ODD   = 1'(PARITY_ODD);
  localparam bit               HAS_PAR   = (PARITY_EN != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  // State and datapath registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    // Baud counter runs in every non-idle state and wraps at each bit boundary
    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (bus.Tx_Start) begin
          shift_d = bus.Tx_Data;
          par_d   = (^bus.Tx_Data) ^ PAR_ODD;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q != IDX_LAST) begin
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
            idx_d   = idx_q + IDX_W'(1);
          end else if (HAS_PAR) begin
            state_d = PARITY;
            tx_d    = par_q;
          end else begin
            state_d = STOP;
            tx_d    = 1'b1;
            idx_d   = '0;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
          idx_d   = '0;
        end
      end
      STOP: begin
        // Bit index counts stop bits so the baud counter stays one bit wide
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.Tx      = tx_q;
  assign bus.Tx_Busy = busy_q;
  assign bus.Tx_Done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx. Three instances cover the
// parameter sets (no parity/1 stop, even parity, odd parity/2 stops); one
// stimulus path is steered to the selected instance. Expected line waveforms
// are built from the frame definition (bit list, each bit CLKS_PER_BIT long).
module tb_uart_tx;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       start;
  logic [7:0] data;
  int         sel;

  int checks   = 0;
  int failures = 0;

  always #5 Clock = ~Clock;

  uart_tx_if bus0 ();
  uart_tx_if bus1 ();
  uart_tx_if bus2 ();

  assign bus0.Tx_Start = start && (sel == 0);
  assign bus1.Tx_Start = start && (sel == 1);
  assign bus2.Tx_Start = start && (sel == 2);
  assign bus0.Tx_Data  = data;
  assign bus1.Tx_Data  = data;
  assign bus2.Tx_Data  = data;

  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    u_dut0 (.Clock(Clock), .Reset(Reset), .bus(bus0.slave));
  uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    u_dut1 (.Clock(Clock), .Reset(Reset), .bus(bus1.slave));
  uart_tx #(.CLKS_PER_BIT(5), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2))
    u_dut2 (.Clock(Clock), .Reset(Reset), .bus(bus2.slave));

  // Outputs of the selected instance
  logic tx_o, busy_o, done_o;
  always_comb begin
    case (sel)
      1:       begin tx_o = bus1.Tx; busy_o = bus1.Tx_Busy; done_o = bus1.Tx_Done; end
      2:       begin tx_o = bus2.Tx; busy_o = bus2.Tx_Busy; done_o = bus2.Tx_Done; end
      default: begin tx_o = bus0.Tx; busy_o = bus0.Tx_Busy; done_o = bus0.Tx_Done; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Configuration of each instance
  function automatic int cpb_of(input int s);
    return (s == 2) ? 5 : 4;
  endfunction
  function automatic int pen_of(input int s);
    return (s == 0) ? 0 : 1;
  endfunction
  function automatic int podd_of(input int s);
    return (s == 2) ? 1 : 0;
  endfunction
  function automatic int nstop_of(input int s);
    return (s == 2) ? 2 : 1;
  endfunction
  function automatic int frame_len(input int s);
    return (9 + pen_of(s) + nstop_of(s)) * cpb_of(s);
  endfunction

  // Expected line level k clocks after the accepting edge
  function automatic logic exp_tx(input int s, input logic [7:0] b, input int k);
    int bit_no;
    bit_no = k / cpb_of(s);
    if (bit_no == 0) return 1'b0;
    if (bit_no <= 8) return b[bit_no-1];
    if (pen_of(s) == 1 && bit_no == 9) return ((($countones(b) + podd_of(s)) % 2) == 1);
    return 1'b1;
  endfunction

  task automatic begin_frame(input logic [7:0] b);
    @(negedge Clock);
    start = 1'b1;
    data  = b;
  endtask

  // Observe one frame starting at the negedge after the accepting edge.
  // keep: hold Tx_Start with next_b for a back-to-back frame.
  // inject_at: cycle at which a stray Tx_Start pulse is applied (-1 none).
  // reset_at: cycle after which Reset is asserted (-1 none).
  task automatic observe_frame(input logic [7:0] b, input bit keep, input logic [7:0] next_b,
                               input int inject_at, input int reset_at, input string tag);
    int   n;
    int   cpb;
    int   tx_err;
    int   busy_err;
    int   done_err;
    logic [7:0] rx;
    logic samples[$];
    n = frame_len(sel);
    cpb = cpb_of(sel);
    tx_err = 0; busy_err = 0; done_err = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge Clock);
      samples.push_back(tx_o);
      if (tx_o !== exp_tx(sel, b, k)) tx_err++;
      if (busy_o !== 1'b1) busy_err++;
      if (done_o !== 1'b0) done_err++;
      if (k == reset_at) begin
        check({tag, "_pre_rst_tx"}, tx_err, 0);
        start = 1'b0;
        Reset = 1'b1;
        @(negedge Clock);
        check({tag, "_rst_tx"}, tx_o, 1);
        check({tag, "_rst_busy"}, busy_o, 0);
        check({tag, "_rst_done"}, done_o, 0);
        Reset = 1'b0;
        @(negedge Clock);
        check({tag, "_post_rst_done"}, done_o, 0);
        check({tag, "_post_rst_busy"}, busy_o, 0);
        return;
      end
      if (keep) begin
        start = 1'b1;
        data  = next_b;
      end else begin
        start = (k == inject_at);
        data  = (k == inject_at) ? 8'h11 : 8'($urandom);
      end
    end
    check({tag, "_tx_wave"}, tx_err, 0);
    check({tag, "_busy_len"}, busy_err, 0);
    check({tag, "_done_early"}, done_err, 0);
    for (int i = 0; i < 8; i++) rx[i] = samples[(1 + i) * cpb + cpb / 2];
    check({tag, "_decode"}, rx, b);
    @(negedge Clock);
    check({tag, "_end_busy"}, busy_o, 0);
    check({tag, "_end_done"}, done_o, 1);
    check({tag, "_end_tx"}, tx_o, 1);
    if (!keep) begin
      start = 1'b0;
      @(negedge Clock);
      check({tag, "_idle_busy"}, busy_o, 0);
      check({tag, "_idle_done"}, done_o, 0);
      check({tag, "_idle_tx"}, tx_o, 1);
    end
  endtask

  initial begin
    logic [7:0] b;
    Reset = 1'b1;
    start = 1'b0;
    data  = 8'h00;
    sel   = 0;
    repeat (3) @(negedge Clock);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check("reset_tx", tx_o, 1);
      check("reset_busy", busy_o, 0);
      check("reset_done", done_o, 0);
    end
    sel = 0;
    @(negedge Clock);
    Reset = 1'b0;

    // Basic 8N1 frame
    begin_frame(8'hA5);
    observe_frame(8'hA5, 1'b0, 8'h00, -1, -1, "basic");

    // Back-to-back with Tx_Start held high
    begin_frame(8'h55);
    observe_frame(8'h55, 1'b1, 8'h33, -1, -1, "b2b_first");
    observe_frame(8'h33, 1'b0, 8'h00, -1, -1, "b2b_second");

    // Stray Tx_Start during a frame is ignored
    begin_frame(8'h80);
    observe_frame(8'h80, 1'b0, 8'h00, 12, -1, "ignored");

    // Mid-frame reset, then a clean frame
    begin_frame(8'hE7);
    observe_frame(8'hE7, 1'b0, 8'h00, -1, 17, "midrst");
    begin_frame(8'h3C);
    observe_frame(8'h3C, 1'b0, 8'h00, -1, -1, "after_rst");

    // Reset and Tx_Start on the same edge: byte dropped
    @(negedge Clock);
    start = 1'b1;
    data  = 8'hC3;
    Reset = 1'b1;
    @(negedge Clock);
    check("rst_start_busy", busy_o, 0);
    check("rst_start_tx", tx_o, 1);
    start = 1'b0;
    Reset = 1'b0;
    @(negedge Clock);
    check("rst_start_dropped", busy_o, 0);

    // Parity and stop-bit variants
    sel = 1;
    begin_frame(8'h07);
    observe_frame(8'h07, 1'b0, 8'h00, -1, -1, "par_even");
    sel = 2;
    begin_frame(8'h00);
    observe_frame(8'h00, 1'b0, 8'h00, -1, -1, "par_odd");
    begin_frame(8'hFF);
    observe_frame(8'hFF, 1'b0, 8'h00, -1, -1, "two_stop");

    // Random bytes on random configurations
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      sel = int'($urandom_range(0, 2));
      b = 8'($urandom);
      begin_frame(b);
      observe_frame(b, 1'b0, 8'h00, -1, -1, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
